// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Execute-stage sequencer around a 32-bit combinational ALU.
//                Registers the ALU source operands and select code, captures
//                the ALU result and a subtract-qualified zero flag, and hands
//                the result downstream through a valid/ready handshake.
//                One operation is in flight at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec_stage #(
    parameter int WORD_SIZE = 32,
    parameter int IMM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // upstream (decode / register file)
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] rs_data,
    input  logic [WORD_SIZE-1:0] rt_data,
    input  logic [WORD_SIZE-1:0] pc_in,
    input  logic [IMM_WIDTH-1:0] imm_in,
    input  logic                 src_a_sel,
    input  logic [1:0]           src_b_sel,
    input  logic [3:0]           alu_op,
    input  logic                 flush,
    // ALU interface
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic [3:0]           alu_sel,
    input  logic [WORD_SIZE-1:0] alu_result,
    input  logic                 alu_zero,
    // downstream (writeback / branch)
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] alu_out,
    output logic                 zero_out,
    output logic                 op_illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WORD_SIZE-1:0] c_CONST_FOUR = {{(WORD_SIZE-3){1'b0}}, 3'b100};
    localparam logic [3:0]           c_OP_SUB     = 4'h3;

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [WORD_SIZE-1:0]   r_alu_a;
    logic [WORD_SIZE-1:0]   r_alu_b;
    logic [3:0]             r_alu_sel;
    logic [WORD_SIZE-1:0]   r_alu_out;
    logic                   r_zero_out;
    logic                   r_op_illegal;

    logic [WORD_SIZE-1:0]   w_src_a;
    logic [WORD_SIZE-1:0]   w_src_b;

    // Operand source muxes feeding the ALU input registers
    always_comb begin
        w_src_a = src_a_sel ? pc_in : rs_data;
        case (src_b_sel)
            2'd0:    w_src_b = rt_data;
            2'd1:    w_src_b = {{(WORD_SIZE-IMM_WIDTH){imm_in[IMM_WIDTH-1]}}, imm_in};
            2'd2:    w_src_b = {{(WORD_SIZE-IMM_WIDTH){1'b0}}, imm_in};
            default: w_src_b = c_CONST_FOUR;
        endcase
    end

    // Sequencer: IDLE accepts, EXEC captures the ALU result, DONE holds it
    // until consumed. Reset beats flush; flush beats accept and out_ready.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= 4'h0;
            r_alu_out    <= '0;
            r_zero_out   <= 1'b0;
            r_op_illegal <= 1'b0;
        end else if (flush) begin
            // Datapath registers are deliberately left untouched on abort
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_op_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_alu_a      <= w_src_a;
                        r_alu_b      <= w_src_b;
                        r_alu_sel    <= alu_op;
                        r_op_illegal <= alu_op[3];
                        r_in_ready   <= 1'b0;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_alu_out   <= alu_result;
                    // The ALU only drives zero meaningfully for subtract
                    r_zero_out  <= (r_alu_sel == c_OP_SUB) ? alu_zero : 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign alu_out    = r_alu_out;
    assign zero_out   = r_zero_out;
    assign op_illegal = r_op_illegal;

endmodule
`default_nettype wire
